// File: rtl/ttc_apb_pkg.sv
// ---------------------------------------------------------------------------
// ttc_apb_pkg
// Shared types and constants for the TTC APB burst initiator: FSM state
// encoding, command status codes, the APB word stride, and the TC/TM window
// base addresses used by system integration.
// ---------------------------------------------------------------------------
package ttc_apb_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP   = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_FIN    = 3'd4
    } apb_state_t;

    // Command result codes reported on Status
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;

    // Byte stride between consecutive 32-bit words
    localparam int unsigned APB_WORD_STEP = 4;

    // Receive windows (TC frames in) and transmit windows (TM frames out)
    localparam logic [31:0] RX_WIN0_BASE = 32'h3000_6000;
    localparam logic [31:0] RX_WIN1_BASE = 32'h3000_8000;
    localparam logic [31:0] TX_WIN0_BASE = 32'h3000_0800;
    localparam logic [31:0] TX_WIN1_BASE = 32'h3000_1000;

endpackage

// File: rtl/apb_burst_master.sv
// ---------------------------------------------------------------------------
// apb_burst_master
// APB3 initiator that runs a command-driven sequence of 32-bit single
// transfers at incrementing word addresses. Read data leaves on a
// valid/ready stream with a single-entry output register; write data is
// popped from an input stream. Each transfer has a wait-state timeout.
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   Cmd_Valid/Cmd_Ready      command handshake (ready only in IDLE)
//   Cmd_Write/Addr/Count     direction, start byte address, word count
//   Cmd_Abort                abort request, honoured between words
//   Wr_Data/Wr_Valid         write stream in
//   Wr_Ready                 one-cycle pop strobe, registered: it is high
//                            in the cycle after the word was captured
//   Rd_Data/Rd_Valid/Rd_Ready read stream out
//   PADDR..PREADY            APB3 initiator interface
//   Busy, Done, Status       activity, completion pulse, last result
//   Words_Done               words completed in the current/last command
// ---------------------------------------------------------------------------
module apb_burst_master
    import ttc_apb_pkg::*;
#(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic             Cmd_Write,
    input  logic [31:0]      Cmd_Addr,
    input  logic [CNT_W-1:0] Cmd_Count,
    input  logic             Cmd_Abort,
    input  logic [31:0]      Wr_Data,
    input  logic             Wr_Valid,
    output logic             Wr_Ready,
    output logic [31:0]      Rd_Data,
    output logic             Rd_Valid,
    input  logic             Rd_Ready,
    output logic [31:0]      PADDR,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [31:0]      PWDATA,
    input  logic [31:0]      PRDATA,
    input  logic             PREADY,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       Status,
    output logic [CNT_W-1:0] Words_Done
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    apb_state_t       state;
    logic [CNT_W-1:0] remaining;
    logic [TO_W-1:0]  to_cnt;
    logic [1:0]       fin_status;   // result captured on entry to FIN, published with Done

    // Address LSBs are forced to zero and never looked at
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Cmd_Addr[1:0];

    // Command sequencer, APB drive and stream handshakes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            to_cnt     <= '0;
            fin_status <= ST_OK;
            Cmd_Ready  <= 1'b1;
            Wr_Ready   <= 1'b0;
            Rd_Data    <= '0;
            Rd_Valid   <= 1'b0;
            PADDR      <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Status     <= ST_OK;
            Words_Done <= '0;
        end else begin
            Done     <= 1'b0;
            Wr_Ready <= 1'b0;

            // Output register drains independently of the sequencer
            if (Rd_Valid && Rd_Ready) begin
                Rd_Valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (Cmd_Valid) begin
                        PWRITE     <= Cmd_Write;
                        PADDR      <= {Cmd_Addr[31:2], 2'b00};
                        remaining  <= Cmd_Count;
                        Words_Done <= '0;
                        Cmd_Ready  <= 1'b0;
                        Busy       <= 1'b1;
                        if (Cmd_Count == '0) begin
                            fin_status <= ST_OK;
                            state      <= S_FIN;
                        end else begin
                            state <= S_PREP;
                        end
                    end
                end

                S_PREP: begin
                    if (Cmd_Abort) begin
                        fin_status <= ST_ABORT;
                        state      <= S_FIN;
                    end else if (PWRITE) begin
                        if (Wr_Valid) begin
                            PWDATA   <= Wr_Data;
                            Wr_Ready <= 1'b1;
                            PSEL     <= 1'b1;
                            state    <= S_SETUP;
                        end
                    end else if (!Rd_Valid || Rd_Ready) begin
                        // Output register is free (or frees this cycle), so the
                        // next read can never overwrite an unaccepted word
                        PSEL  <= 1'b1;
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    PENABLE <= 1'b1;
                    to_cnt  <= '0;
                    state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (PREADY) begin
                        if (!PWRITE) begin
                            Rd_Data  <= PRDATA;
                            Rd_Valid <= 1'b1;
                        end
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        PADDR      <= PADDR + 32'(APB_WORD_STEP);
                        Words_Done <= Words_Done + CNT_W'(1);
                        remaining  <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            fin_status <= ST_OK;
                            state      <= S_FIN;
                        end else begin
                            state <= S_PREP;
                        end
                    end else if (to_cnt + TO_W'(1) == TO_W'(TIMEOUT)) begin
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        fin_status <= ST_TIMEOUT;
                        state      <= S_FIN;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_FIN: begin
                    Done      <= 1'b1;
                    Status    <= fin_status;
                    Busy      <= 1'b0;
                    Cmd_Ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_burst_master.sv
// ---------------------------------------------------------------------------
// tb_apb_burst_master
// Directed plus randomized bench for apb_burst_master. A behavioural APB
// slave, write-stream source and read-stream sink run on the falling edge;
// expected transfers are derived from the command (base + 4*i, wrap mod 2^32).
// ---------------------------------------------------------------------------
module tb_apb_burst_master;
    import ttc_apb_pkg::*;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned TMO   = 8;

    logic             Clk;
    logic             Rst;
    logic             Cmd_Valid;
    logic             Cmd_Ready;
    logic             Cmd_Write;
    logic [31:0]      Cmd_Addr;
    logic [CNT_W-1:0] Cmd_Count;
    logic             Cmd_Abort;
    logic [31:0]      Wr_Data;
    logic             Wr_Valid;
    logic             Wr_Ready;
    logic [31:0]      Rd_Data;
    logic             Rd_Valid;
    logic             Rd_Ready;
    logic [31:0]      PADDR;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [31:0]      PWDATA;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic             Busy;
    logic             Done;
    logic [1:0]       Status;
    logic [CNT_W-1:0] Words_Done;

    apb_burst_master #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Rst(Rst),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
        .Cmd_Addr(Cmd_Addr), .Cmd_Count(Cmd_Count), .Cmd_Abort(Cmd_Abort),
        .Wr_Data(Wr_Data), .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready),
        .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .Busy(Busy), .Done(Done), .Status(Status), .Words_Done(Words_Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment knobs, written only by the stimulus process
    int          wait_states   = 0;
    bit          never_ready   = 1'b0;
    bit          abort_arm     = 1'b0;
    int          abort_after   = 0;
    int          rd_hold_until = 0;
    int          gap_at_pop    = -1;
    int          gap_len       = 0;
    logic [31:0] salt          = 32'h0;
    logic [31:0] wr_src[$];

    // Environment state, written only by the falling-edge process
    int          cyc           = 0;
    int          wcnt          = 0;
    int          wr_idx        = 0;
    int          wr_gap        = 0;
    int          wr_pulses     = 0;
    int          done_pulses   = 0;
    int          access_cycles = 0;
    int          psel_cycles   = 0;
    int          setup_cyc[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    bit          log_we[$];
    logic [31:0] rd_got[$];
    int          rd_acc_cyc[$];

    // Per-command snapshots
    int lb0, rb0, sb0, ra0, wb0, acc0, psel0, wp0, dp0, t_start, t_done;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Slave, write source, read sink and event recorder
    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (PSEL && !PENABLE) setup_cyc.push_back(cyc);
        if (PSEL) psel_cycles++;
        if (Done) done_pulses++;
        if (PSEL && PENABLE) begin
            access_cycles++;
            if (!never_ready && wcnt >= wait_states) begin
                PREADY = 1'b1;
                PRDATA = slave_data(PADDR);
                log_addr.push_back(PADDR);
                log_we.push_back(PWRITE);
                log_data.push_back(PWRITE ? PWDATA : slave_data(PADDR));
            end else begin
                PREADY = 1'b0;
                PRDATA = $urandom;
                wcnt++;
            end
        end else begin
            PREADY = 1'b0;
            wcnt   = 0;
        end

        if (Wr_Ready) begin
            wr_pulses++;
            wr_idx++;
            if (wr_idx == gap_at_pop) wr_gap = gap_len;
        end
        if (wr_gap > 0) begin
            Wr_Valid = 1'b0;
            wr_gap--;
        end else if (wr_idx < wr_src.size()) begin
            Wr_Valid = 1'b1;
            Wr_Data  = wr_src[wr_idx];
        end else begin
            Wr_Valid = 1'b0;
            Wr_Data  = 32'h0;
        end

        Rd_Ready = (cyc >= rd_hold_until);
        if (Rd_Valid && Rd_Ready) begin
            rd_got.push_back(Rd_Data);
            rd_acc_cyc.push_back(cyc);
        end

        Cmd_Abort = abort_arm && (log_addr.size() == abort_after) && !PSEL && Busy;
    end

    task automatic snapshot();
        lb0   = log_addr.size();
        rb0   = rd_got.size();
        sb0   = setup_cyc.size();
        ra0   = rd_acc_cyc.size();
        acc0  = access_cycles;
        psel0 = psel_cycles;
        wp0   = wr_pulses;
        dp0   = done_pulses;
    endtask

    task automatic push_words(input int n);
        wb0 = wr_src.size();
        for (int i = 0; i < n; i++) wr_src.push_back($urandom);
    endtask

    // Issue one command and wait (bounded) for its Done pulse
    task automatic run_cmd(input bit we, input logic [31:0] addr, input int cnt);
        bit got;
        @(negedge Clk); #1;
        check("cmd_ready_idle", 32'(Cmd_Ready), 32'd1);
        snapshot();
        Cmd_Write = we;
        Cmd_Addr  = addr;
        Cmd_Count = CNT_W'(cnt);
        Cmd_Valid = 1'b1;
        t_start   = cyc;
        @(posedge Clk); #1;
        Cmd_Valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge Clk); #1;
            if (Done) got = 1'b1;
        end
        t_done = cyc;
        check("done_seen", 32'(got), 32'd1);
    endtask

    task automatic check_result(input logic [1:0] st, input int words);
        check("status", 32'(Status), 32'(st));
        check("words_done", 32'(Words_Done), 32'(words));
    endtask

    task automatic post_cmd();
        @(negedge Clk); #1;
        check("done_one_cycle", 32'(Done), 32'd0);
        check("done_pulse_count", 32'(done_pulses - dp0), 32'd1);
        check("busy_after", 32'(Busy), 32'd0);
    endtask

    // Compare logged APB transfers and delivered read words against the model
    task automatic check_xfers(input bit we, input logic [31:0] addr, input int n);
        check("xfer_count", 32'(log_addr.size() - lb0), 32'(n));
        check("wr_ready_pulses", 32'(wr_pulses - wp0), we ? 32'(n) : 32'd0);
        if (!we) check("rd_count", 32'(rd_got.size() - rb0), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [31:0] ea;
            ea = {addr[31:2], 2'b00} + 32'(4 * i);
            if (lb0 + i < log_addr.size()) begin
                check("paddr", log_addr[lb0 + i], ea);
                check("pwrite", 32'(log_we[lb0 + i]), 32'(we));
                check(we ? "pwdata" : "prdata", log_data[lb0 + i],
                      we ? wr_src[wb0 + i] : slave_data(ea));
            end
            if (!we && (rb0 + i < rd_got.size()))
                check("rd_data", rd_got[rb0 + i], slave_data(ea));
        end
    endtask

    initial begin
        Rst       = 1'b1;
        Cmd_Valid = 1'b0;
        Cmd_Write = 1'b0;
        Cmd_Addr  = 32'h0;
        Cmd_Count = '0;
        salt      = $urandom;
        repeat (3) @(negedge Clk);
        #1;

        // Reset state
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_rd_valid", 32'(Rd_Valid), 32'd0);
        check("rst_rd_data", Rd_Data, 32'h0);
        check("rst_wr_ready", 32'(Wr_Ready), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_status", 32'(Status), 32'd0);
        check("rst_words", 32'(Words_Done), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
        Rst = 1'b0;

        // Read 4 words from RX window 0, 2 wait states
        wait_states = 2;
        run_cmd(1'b0, RX_WIN0_BASE, 4);
        check_result(ST_OK, 4);
        post_cmd();
        repeat (2) @(negedge Clk);
        #1;
        check_xfers(1'b0, RX_WIN0_BASE, 4);

        // Write 3 words to TX window 0, stream stalls 10 cycles before word 2
        wait_states = 0;
        push_words(3);
        gap_at_pop = wr_idx + 1;
        gap_len    = 10;
        run_cmd(1'b1, TX_WIN0_BASE, 3);
        check_result(ST_OK, 3);
        check_xfers(1'b1, TX_WIN0_BASE, 3);
        check("stall_psel_cycles", 32'(psel_cycles - psel0), 32'd6);
        if (setup_cyc.size() >= sb0 + 2)
            check("stall_setup_gap", 32'(setup_cyc[sb0 + 1] - setup_cyc[sb0]), 32'd11);
        post_cmd();
        gap_at_pop = -1;

        // Read 2 words with the sink blocked for ~20 cycles
        wait_states   = 1;
        rd_hold_until = cyc + 22;
        run_cmd(1'b0, RX_WIN1_BASE, 2);
        check_result(ST_OK, 2);
        if (setup_cyc.size() >= sb0 + 2 && rd_acc_cyc.size() > ra0) begin
            check("bp_setup_after_accept", 32'(setup_cyc[sb0 + 1]), 32'(rd_acc_cyc[ra0] + 1));
            check("bp_stall_long", 32'(setup_cyc[sb0 + 1] - setup_cyc[sb0] >= 15), 32'd1);
        end
        post_cmd();
        repeat (2) @(negedge Clk);
        #1;
        check_xfers(1'b0, RX_WIN1_BASE, 2);

        // Slave never ready: timeout after TMO ACCESS cycles
        never_ready = 1'b1;
        run_cmd(1'b0, RX_WIN0_BASE, 2);
        check_result(ST_TIMEOUT, 0);
        check("to_access_cycles", 32'(access_cycles - acc0), 32'(TMO));
        check("to_psel_cycles", 32'(psel_cycles - psel0), 32'(TMO + 1));
        check("to_psel_low", 32'(PSEL), 32'd0);
        post_cmd();
        never_ready = 1'b0;

        // Address wrap; low address bits are ignored
        wait_states = 1;
        run_cmd(1'b0, 32'hFFFF_FFFB, 3);
        check_result(ST_OK, 3);
        post_cmd();
        repeat (2) @(negedge Clk);
        #1;
        check_xfers(1'b0, 32'hFFFF_FFF8, 3);
        if (log_addr.size() >= lb0 + 3) check("wrap_addr", log_addr[lb0 + 2], 32'h0);

        // Zero-length command: Done two cycles after Cmd_Valid, no APB activity
        run_cmd(1'b0, RX_WIN0_BASE, 0);
        check("zero_latency", 32'(t_done - t_start), 32'd2);
        check_result(ST_OK, 0);
        check("zero_psel", 32'(psel_cycles - psel0), 32'd0);
        post_cmd();

        // Abort after the first of five words
        wait_states = 0;
        abort_after = log_addr.size() + 1;
        abort_arm   = 1'b1;
        run_cmd(1'b0, RX_WIN1_BASE, 5);
        check_result(ST_ABORT, 1);
        check("abort_xfers", 32'(log_addr.size() - lb0), 32'd1);
        post_cmd();
        abort_arm = 1'b0;
        repeat (2) @(negedge Clk);

        // Zero-wait throughput: one SETUP every 3 cycles
        run_cmd(1'b0, TX_WIN1_BASE, 4);
        check_result(ST_OK, 4);
        for (int i = 1; i < 4; i++)
            if (setup_cyc.size() > sb0 + i)
                check("throughput", 32'(setup_cyc[sb0 + i] - setup_cyc[sb0 + i - 1]), 32'd3);
        post_cmd();
        repeat (2) @(negedge Clk);

        // Randomized commands
        for (int it = 0; it < 6; it++) begin
            bit          we;
            int          cnt;
            logic [31:0] addr;
            we          = 1'($urandom_range(0, 1));
            cnt         = $urandom_range(1, 6);
            addr        = $urandom;
            wait_states = $urandom_range(0, 3);
            if (we) push_words(cnt);
            run_cmd(we, addr, cnt);
            check_result(ST_OK, cnt);
            post_cmd();
            repeat (2) @(negedge Clk);
            #1;
            check_xfers(we, addr, cnt);
        end

        // Last read word stays valid after Done while the sink stalls
        wait_states   = 0;
        rd_hold_until = cyc + 100000;
        run_cmd(1'b0, RX_WIN0_BASE, 1);
        post_cmd();
        check("rd_valid_held", 32'(Rd_Valid), 32'd1);

        // Reset during ACCESS of a write
        begin
            bit got;
            never_ready = 1'b1;
            push_words(2);
            @(negedge Clk); #1;
            Cmd_Write = 1'b1;
            Cmd_Addr  = TX_WIN1_BASE;
            Cmd_Count = CNT_W'(2);
            Cmd_Valid = 1'b1;
            @(posedge Clk); #1;
            Cmd_Valid = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge Clk); #1;
                if (PSEL && PENABLE) got = 1'b1;
            end
            check("reach_access", 32'(got), 32'd1);
            check("busy_in_access", 32'(Busy), 32'd1);
            check("cmd_ready_in_access", 32'(Cmd_Ready), 32'd0);
            Rst = 1'b1;
            @(posedge Clk); #1;
            check("rst_mid_psel", 32'(PSEL), 32'd0);
            check("rst_mid_penable", 32'(PENABLE), 32'd0);
            check("rst_mid_cmd_ready", 32'(Cmd_Ready), 32'd1);
            check("rst_mid_rd_valid", 32'(Rd_Valid), 32'd0);
            check("rst_mid_busy", 32'(Busy), 32'd0);
            @(negedge Clk); #1;
            Rst           = 1'b0;
            never_ready   = 1'b0;
            rd_hold_until = cyc;
        end

        // Recovery read after reset
        wait_states = 1;
        run_cmd(1'b0, TX_WIN0_BASE, 2);
        check_result(ST_OK, 2);
        post_cmd();
        repeat (2) @(negedge Clk);
        #1;
        check_xfers(1'b0, TX_WIN0_BASE, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
